// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, NOP word and
// fetch-controller state encoding.
package cpu_pkg;

  localparam int INST_W = 32;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Saturating wait-state counter for instruction fetches.
// tc flags the last permitted REQ cycle.
module fetch_timeout_ctr #(
  parameter int TIMEOUT = 15,
  localparam int W = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory fetch controller between Fetch and Decode:
// req/ack memory access, redirect cancel, misalign/timeout NOPs.
module imem_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int TIMEOUT = 15,
  parameter logic [31:0] NOP_INST = cpu_pkg::NOP_INST
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       pc_addr,
  input  logic              pc_valid,
  input  logic              redirect,
  output logic              pc_stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       inst,
  output logic [31:0]       inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic              misalign_err,
  output logic              bus_err
);

  state_e state;
  logic   drop;
  logic   accept;
  logic   aligned;
  logic   start;
  logic   tc;

  assign aligned  = (pc_addr[1:0] == 2'b00);
  assign accept   = (state == S_IDLE) ||
                    ((state == S_HOLD) && inst_ready && !redirect);
  assign pc_stall = pc_valid && !accept;
  assign start    = accept && pc_valid && aligned;

  fetch_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_ctr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (start),
    .en   (state == S_REQ),
    .tc   (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      inst         <= NOP_INST;
      inst_pc      <= '0;
      inst_valid   <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      drop         <= 1'b0;
    end else begin
      unique case (state)
        S_REQ: begin
          // an ack coinciding with the timeout still delivers data
          if (mem_ack || tc) begin
            mem_req <= 1'b0;
            drop    <= 1'b0;
            if (drop || redirect) begin
              state <= S_IDLE;
            end else begin
              state        <= S_HOLD;
              inst_valid   <= 1'b1;
              inst         <= mem_ack ? mem_rdata : NOP_INST;
              bus_err      <= !mem_ack;
              misalign_err <= 1'b0;
            end
          end else if (redirect) begin
            drop <= 1'b1;
          end
        end
        default: begin
          if ((state == S_HOLD) && redirect) begin
            inst_valid <= 1'b0;
            state      <= S_IDLE;
          end else if (accept) begin
            if (!pc_valid) begin
              inst_valid <= 1'b0;
              state      <= S_IDLE;
            end else if (aligned) begin
              mem_req      <= 1'b1;
              mem_addr     <= pc_addr[ADDR_W-1:0];
              inst_pc      <= pc_addr;
              inst_valid   <= 1'b0;
              misalign_err <= 1'b0;
              bus_err      <= 1'b0;
              state        <= S_REQ;
            end else begin
              inst         <= NOP_INST;
              inst_pc      <= pc_addr;
              misalign_err <= 1'b1;
              bus_err      <= 1'b0;
              inst_valid   <= 1'b1;
              state        <= S_HOLD;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed scenarios
// plus randomized fetch transactions against a transaction model.
module tb_imem_fetch_ctrl;

  localparam int TIMEOUT = 15;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_addr;
  logic        pc_valid;
  logic        redirect;
  logic        pc_stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        misalign_err;
  logic        bus_err;

  int n_chk;
  int n_err;

  imem_fetch_ctrl #(
    .ADDR_W  (32),
    .TIMEOUT (TIMEOUT),
    .NOP_INST(NOP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_addr     (pc_addr),
    .pc_valid    (pc_valid),
    .redirect    (redirect),
    .pc_stall    (pc_stall),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .misalign_err(misalign_err),
    .bus_err     (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_hold(input logic [31:0] pc,
                          input logic [31:0] e_inst,
                          input bit mis, input bit bus);
    check("hold_valid", inst_valid, 1);
    check("hold_inst", inst, e_inst);
    check("hold_pc", inst_pc, pc);
    check("hold_mis", misalign_err, 32'(mis));
    check("hold_bus", bus_err, 32'(bus));
    check("hold_noreq", mem_req, 0);
  endtask

  // wt: wait cycles before ack (ack in REQ cycle wt+1, none if too late)
  // redir_at: REQ cycle carrying a redirect, 0 for none
  task automatic do_fetch(input logic [31:0] pc, input int wt,
                          input int redir_at, input int hold,
                          input bit hold_redir, input bit leave);
    logic [31:0] rd;
    logic [31:0] e_inst;
    bit          drop_seen;
    bit          got_ack;
    bit          is_mis;
    int          n_req;
    is_mis    = (pc[1:0] != 2'b00);
    rd        = $urandom;
    n_req     = (wt < TIMEOUT) ? wt + 1 : TIMEOUT;
    drop_seen = 0;
    got_ack   = 0;
    pc_addr    = pc;
    pc_valid   = 1;
    inst_ready = 1;
    #1;
    check("stall_accept", pc_stall, 0);
    @(negedge clk);
    inst_ready = 0;
    if (is_mis) begin
      pc_valid = 0;
      #1;
      check("mis_noreq", mem_req, 0);
      e_inst = NOP;
    end else begin
      for (int c = 1; c <= n_req; c++) begin
        check("req", mem_req, 1);
        check("addr", mem_addr, pc);
        check("stall_req", pc_stall, 1);
        mem_ack   = (c == wt + 1);
        mem_rdata = mem_ack ? rd : $urandom;
        redirect  = (c == redir_at);
        if (redirect) drop_seen = 1;
        if (mem_ack) got_ack = 1;
        @(negedge clk);
        mem_ack  = 0;
        redirect = 0;
      end
      pc_valid = 0;
      #1;
      check("req_end", mem_req, 0);
      e_inst = got_ack ? rd : NOP;
    end
    if (drop_seen) begin
      check("dropped", inst_valid, 0);
      @(negedge clk);
      check("dropped_idle", inst_valid, 0);
      return;
    end
    chk_hold(pc, e_inst, is_mis, !is_mis && !got_ack);
    repeat (hold) begin
      @(negedge clk);
      chk_hold(pc, e_inst, is_mis, !is_mis && !got_ack);
    end
    if (hold_redir) begin
      redirect   = 1;
      inst_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      redirect   = 0;
      inst_ready = 0;
      #1;
      check("redir_hold", inst_valid, 0);
    end else if (!leave) begin
      inst_ready = 1;
      @(negedge clk);
      inst_ready = 0;
      #1;
      check("consume", inst_valid, 0);
    end
  endtask

  initial begin
    logic [31:0] pc;
    int          wt;
    int          ra;
    int          nr;
    bit          hr;
    n_chk      = 0;
    n_err      = 0;
    rst_n      = 0;
    pc_addr    = 0;
    pc_valid   = 0;
    redirect   = 0;
    mem_rdata  = 0;
    mem_ack    = 0;
    inst_ready = 0;
    repeat (2) @(negedge clk);
    check("rst_req", mem_req, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_inst", inst, NOP);
    check("rst_pc", inst_pc, 0);
    check("rst_valid", inst_valid, 0);
    check("rst_mis", misalign_err, 0);
    check("rst_bus", bus_err, 0);
    rst_n = 1;
    @(negedge clk);

    do_fetch(32'h14, 0, 0, 0, 0, 0);
    do_fetch(32'h40, 3, 0, 2, 0, 0);
    do_fetch(32'h80, 2, 1, 0, 0, 0);
    do_fetch(32'h20, 1, 0, 1, 0, 0);
    do_fetch(32'h100, 40, 0, 1, 0, 0);
    do_fetch(32'h104, TIMEOUT - 1, 0, 0, 0, 0);
    do_fetch(32'h6, 0, 0, 1, 0, 0);
    do_fetch(32'h200, 1, 0, 0, 0, 1);
    do_fetch(32'h204, 0, 0, 0, 0, 1);
    do_fetch(32'h209, 0, 0, 0, 0, 1);
    do_fetch(32'h300, 0, 0, 1, 1, 0);
    do_fetch(32'h304, 40, 5, 0, 0, 0);

    // async reset while a request is outstanding
    pc_addr  = 32'h400;
    pc_valid = 1;
    @(negedge clk);
    pc_valid = 0;
    @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    check("arst_req", mem_req, 0);
    check("arst_valid", inst_valid, 0);
    check("arst_addr", mem_addr, 0);
    @(negedge clk);
    rst_n     = 1;
    mem_ack   = 1;
    mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    mem_ack = 0;
    #1;
    check("late_ack_req", mem_req, 0);
    check("late_ack_valid", inst_valid, 0);
    check("late_ack_bus", bus_err, 0);

    // async reset while holding a bus-error NOP
    do_fetch(32'h500, 40, 0, 0, 0, 1);
    #2;
    rst_n = 0;
    #1;
    check("arst_bus", bus_err, 0);
    check("arst_hvalid", inst_valid, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    for (int i = 0; i < 200; i++) begin
      pc = $urandom;
      if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
      else pc[1:0] = 2'($urandom_range(1, 3));
      wt = $urandom_range(0, 20);
      nr = (wt < TIMEOUT) ? wt + 1 : TIMEOUT;
      ra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, nr) : 0;
      hr = ($urandom_range(0, 7) == 0);
      do_fetch(pc, wt, ra, $urandom_range(0, 3), hr,
               !hr && ($urandom_range(0, 2) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Instruction-memory access controller sitting directly downstream of the Fetch stage.
- Takes the PC produced by Fetch and runs a req/ack transaction to an instruction memory with variable wait states.
- Holds the returned instruction for Decode with a valid/ready handshake, and stalls Fetch while busy.
- Cancels in-flight fetches on a branch/jump redirect, and converts misaligned PCs and memory timeouts into a NOP plus an error flag.

Parameters:
- ADDR_W, 32: width of mem_addr; the low ADDR_W bits of pc_addr are used.
- TIMEOUT, 15: maximum number of REQ cycles without mem_ack before a bus error is declared; must be ≥1.
- NOP_INST, 32'h0000_0000: instruction word substituted on a misalign or timeout error.

Ports:
- Clock, input, 1: single clock; all state changes on the rising edge.
- Reset, input, 1: asynchronous, active-low reset.
- pc_addr, input, 32: PC from Fetch (its addr output).
- pc_valid, input, 1: pc_addr holds a new address to fetch.
- redirect, input, 1: branch taken or jump (B&Z | J); any fetch in progress is stale.
- pc_stall, output, 1: Fetch must hold its PC this cycle.
- mem_req, output, 1: memory request, held until acknowledged.
- mem_addr, output, ADDR_W: memory word address; stable while mem_req=1.
- mem_rdata, input, 32: instruction from memory; valid only when mem_ack=1.
- mem_ack, input, 1: one-cycle acknowledge from memory.
- inst, output, 32: instruction to Decode.
- inst_pc, output, 32: PC of inst.
- inst_valid, output, 1: inst/inst_pc are valid.
- inst_ready, input, 1: Decode consumes inst this cycle.
- misalign_err, output, 1: current inst came from a PC with pc_addr[1:0]≠0.
- bus_err, output, 1: current inst came from a timed-out fetch.

Behaviour:
- Reset (async, Reset=0) forces:
  - state IDLE; mem_req=0; mem_addr=0.
  - inst=NOP_INST; inst_pc=0; inst_valid=0.
  - misalign_err=0; bus_err=0; drop=0; timer=0.
  - Reset asserted mid-transaction abandons the transaction; a late mem_ack after reset release is ignored in IDLE.
- States are IDLE, REQ and HOLD.
- accept = (state==IDLE) | (state==HOLD & inst_ready & ~redirect).
- pc_stall = pc_valid & ~accept. This is combinational, with no register.
- IDLE:
  - pc_valid & aligned: latch mem_addr and inst_pc, set mem_req=1, timer=0, go to REQ.
  - pc_valid & misaligned: inst=NOP_INST, inst_pc=pc_addr, misalign_err=1, inst_valid=1, go to HOLD; no memory access is made.
  - redirect is ignored in IDLE.
- REQ:
  - mem_req stays high; mem_addr is frozen; timer increments each cycle.
  - On mem_ack: mem_req=0 next cycle.
    - If drop=1 or redirect=1 in that cycle: discard the data, clear drop, go to IDLE.
    - Otherwise: inst=mem_rdata, inst_valid=1, errors=0, go to HOLD.
  - redirect without mem_ack: set drop=1 and keep waiting; the request is never withdrawn before ack.
  - timer==TIMEOUT-1 with no ack: mem_req=0 next cycle.
    - If drop=0 (and no redirect this cycle): inst=NOP_INST, bus_err=1, inst_valid=1, go to HOLD.
    - If drop=1: go to IDLE silently.
  - A mem_ack in the same cycle as the timeout wins: it is treated as a normal ack.
- HOLD:
  - inst_valid=1; inst, inst_pc and error flags are stable until consumed.
  - redirect: inst_valid=0, go to IDLE (consume suppressed).
  - inst_ready with pc_valid: back-to-back, handled as the IDLE decision in the same cycle.
  - inst_ready without pc_valid: inst_valid=0, go to IDLE.
- Latency:
  - With zero-wait memory (ack in the first REQ cycle): pc_valid at edge N, mem_req at N+1, inst_valid at N+2.
  - Throughput is one instruction per 2 cycles at best.
- timer is $clog2(TIMEOUT+1) bits and saturates; it never wraps.

Decomposition:
- Shared package cpu_pkg:
  - state encoding localparams S_IDLE/S_REQ/S_HOLD;
  - INST_W=32;
  - NOP_INST default constant (shared with Decode).
- One natural sub-module, fetch_timeout_ctr: clear/enable/saturating counter with a terminal-count output.
- Everything else stays in the single FSM module.

Test Plan:
- Zero-wait fetch: Reset pulse low, then pc_addr=0x14 with pc_valid=1, mem_ack=1 with rdata=0x2008_0005 in the first REQ cycle, inst_ready=1 → mem_addr=0x14 for exactly 1 cycle; inst=0x20080005, inst_pc=0x14, inst_valid 2 cycles after pc_valid; pc_stall=1 during REQ.
- Wait states: ack delayed 3 cycles → mem_req/mem_addr stable for 4 cycles; inst_valid held while inst_ready=0 for 2 cycles, with inst unchanged.
- Redirect in flight: redirect in REQ cycle 1, ack with 0xDEADBEEF in cycle 3 → inst_valid never rises; state back to IDLE; the next pc_addr=0x20 is fetched normally.
- Timeout: TIMEOUT=15, mem_ack never asserted → mem_req drops after 15 cycles; inst=0, bus_err=1, inst_valid=1. Repeat with ack arriving in cycle 15 → normal data, bus_err=0.
- Misalign: pc_addr=0x6 → no mem_req; inst=0, inst_pc=0x6, misalign_err=1, inst_valid next cycle.
- Async reset: Reset=0 mid-REQ, between clock edges → mem_req, inst_valid and errors clear immediately; an ack after release is ignored.
